// File: rtl/row_router_ctrl.sv
// Tile sequencer for a bank of row routers sharing one SRAM read port:
// it runs clear, MPP load, address sweep, MISO drain and done for each tile.
module row_router_ctrl #(
  parameter int NUM_ROUTERS = 3,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [ADDR_WIDTH-1:0]  i_addr_start,
  input  logic [ADDR_WIDTH-1:0]  i_addr_end,
  input  logic                   i_ag_valid,
  input  logic [NUM_ROUTERS-1:0] i_mpp_empty,
  input  logic [NUM_ROUTERS-1:0] i_miso_empty,
  input  logic                   i_pop_ready,
  output logic                   o_reg_clear,
  output logic                   o_mpp_write_en,
  output logic                   o_sram_rd_en,
  output logic [ADDR_WIDTH-1:0]  o_sram_addr,
  output logic                   o_ac_en,
  output logic [ADDR_WIDTH-1:0]  o_ac_addr,
  output logic                   o_miso_pop_en,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_miss
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_FETCH,
    S_FLUSH,
    S_POP,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   end_q, end_d;
  logic                    miss_q, miss_d;
  logic                    ac_en_q, ac_en_d;
  logic [ADDR_WIDTH-1:0]   ac_addr_q, ac_addr_d;

  logic                    rd_en;
  logic                    wr_en;
  logic                    pop_en;
  logic                    all_mpp_empty;
  logic                    all_miso_empty;

  assign all_mpp_empty  = &i_mpp_empty;
  assign all_miso_empty = &i_miso_empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    end_d   = end_q;
    miss_d  = miss_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    pop_en  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          cnt_d   = i_addr_start;
          // An inverted range collapses to a single-address sweep.
          end_d   = (i_addr_end < i_addr_start) ? i_addr_start : i_addr_end;
          miss_d  = 1'b0;
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        state_d = S_LOAD;
      end

      S_LOAD: begin
        wr_en = i_ag_valid;
        if (i_ag_valid) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (all_mpp_empty) begin
          state_d = S_FLUSH;
        end else begin
          rd_en = 1'b1;
          if (cnt_q == end_q) begin
            // Counter parks on the last address so a sweep ending at the
            // top of the address space never wraps.
            state_d = S_FLUSH;
            miss_d  = miss_q | ~all_mpp_empty;
          end else begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
          end
        end
      end

      S_FLUSH: begin
        state_d = S_POP;
      end

      S_POP: begin
        pop_en = i_pop_ready & ~all_miso_empty;
        if (all_miso_empty) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Comparator side sees each read one cycle later, matching SRAM latency.
  always_comb begin
    ac_en_d   = rd_en;
    ac_addr_d = rd_en ? cnt_q : ac_addr_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      end_q     <= '0;
      miss_q    <= 1'b0;
      ac_en_q   <= 1'b0;
      ac_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      end_q     <= end_d;
      miss_q    <= miss_d;
      ac_en_q   <= ac_en_d;
      ac_addr_q <= ac_addr_d;
    end
  end

  assign o_reg_clear    = (state_q == S_CLEAR);
  assign o_mpp_write_en = wr_en;
  assign o_sram_rd_en   = rd_en;
  assign o_sram_addr    = rd_en ? cnt_q : '0;
  assign o_ac_en        = ac_en_q;
  assign o_ac_addr      = ac_addr_q;
  assign o_miso_pop_en  = pop_en;
  assign o_busy         = (state_q != S_IDLE);
  assign o_done         = (state_q == S_DONE);
  assign o_miss         = miss_q;

endmodule
